output_neuron_seq: RTL and testbench
====================================

# output_neuron_seq

Sequential output-layer neuron for the XOR MLP: consumes the hidden layer's ReLU activations as a serial valid/ready stream, one activation per beat. Each accepted activation is multiplied by its weight in signed fixed point and accumulated onto the bias. After NUM_INPUTS beats it presents a saturated score and a binary class bit on a valid/ready output port. It is the receiving end of the hidden-neuron activation interface and produces the network's final prediction.

## Interface
- NUM_INPUTS, 2: activations per inference; must be ≥ 1.
- DATA_WIDTH, 16: width of activations, weights, bias and score; signed two's complement.
- FRAC_BITS, 8: fractional bits of the fixed-point format. Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- weights  in  DATA_WIDTH × NUM_INPUTS (signed, unpacked)  per-input weights; held stable while an inference is in progress.
- bias  in  DATA_WIDTH (signed)  bias; sampled on the first accepted beat of each inference.
- in_data  in  DATA_WIDTH (signed)  activation value.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts a beat this cycle.
- out_score  out  DATA_WIDTH (signed)  saturated weighted sum; registered.
- out_class  out  1  1 when out_score > 0; registered.
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.

## Operation
- FSM states:
  - ACCUM: in_ready=1, out_valid=0.
  - RESULT: in_ready=0, out_valid=1.
- A beat is accepted when in_valid && in_ready.
- Beat index idx runs 0..NUM_INPUTS-1. Beat k uses weights[k].
- Product: full 2·DATA_WIDTH signed product of in_data × weights[idx], then arithmetic right shift by FRAC_BITS (truncation toward −∞).
- Accumulator: ACC_W = 2·DATA_WIDTH + clog2(NUM_INPUTS) + 1 bits. It cannot overflow internally.
  - On beat 0: acc = sext(bias) + product.
  - On later beats: acc += product.
- On accepting beat NUM_INPUTS-1:
  - out_score = acc_next clamped to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
  - out_class = (clamped score > 0). A score of exactly 0 gives class 0.
  - idx returns to 0 and the FSM enters RESULT.
- RESULT:
  - out_score and out_class hold stable until out_valid && out_ready.
  - in_valid is ignored and no beat is consumed.
  - On the output handshake, the FSM returns to ACCUM.
- Reset (any time, including mid-inference):
  - FSM = ACCUM, idx = 0, acc = 0.
  - out_score = 0, out_class = 0, out_valid = 0.
  - in_ready goes to 1 one cycle after rst_n deasserts.
  - A partial inference is discarded.
- Weights or bias changing mid-inference is a usage error. The result is undefined but the protocol stays intact.

## Timing
- in_ready and out_valid are decoded from registered state only; there is no combinational path from inputs.
- Latency: out_valid rises the cycle after the last beat is accepted.
- Throughput: at best NUM_INPUTS + 1 cycles per inference. The first beat of the next inference can be accepted the cycle after the output handshake, not in the same cycle.
- in_valid gaps stall accumulation without corrupting idx or acc.
- out_ready held low stalls indefinitely; no result is dropped.

## Structure
- Shared package mlp_pkg, holding:
  - default DATA_WIDTH and FRAC_BITS;
  - the state enum typedef (ACCUM, RESULT);
  - a saturate function that clamps ACC_W to DATA_WIDTH.
- Sub-module fixed_mac: combinational multiply, shift and add (acc_in, data, weight → acc_out), parameterized by DATA_WIDTH, FRAC_BITS and ACC_W. It is reused by a later sequential hidden layer.

## Test plan
All scenarios use DATA_WIDTH=16, FRAC_BITS=8, NUM_INPUTS=2.
- weights {0x0100, 0xFE00}, bias 0xFF80, beats 0x0100, 0x0080 → out_score 0xFF80 (−0.5), out_class 0, out_valid one cycle after beat 2.
- Same weights and bias, beats 0x0200, 0x0000 → out_score 0x0180, out_class 1.
- Saturation:
  - weights {0x7FFF, 0x7FFF}, bias 0, beats 0x7FFF, 0x7FFF → out_score 0x7FFF, class 1.
  - weights {0x8000, 0x8000}, same beats → out_score 0x8000, class 0.
- Exact zero: weights {0x0100, 0x0100}, bias 0xFF00, beats 0x0080, 0x0080 → score 0x0000, class 0.
- Backpressure: out_ready low for 5 cycles with in_valid pulsing → out_valid and out_score stable, in_ready 0, no beats consumed. Two inferences sent back to back yield two correct results in order.
- Reset mid-inference: accept 1 beat, pulse rst_n low asynchronously → outputs 0 immediately. The next 2 beats (0x0200, 0x0000, scenario-2 weights) → score 0x0180.

Source files
------------

// File: rtl/mlp_pkg.sv
// mlp_pkg: shared fixed-point defaults, FSM state type and accumulator saturation
package mlp_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS = 8;
  localparam int MAX_W = 64;
  typedef enum logic {ACCUM, RESULT} state_t;
  function automatic logic signed [MAX_W-1:0] saturate(input logic signed [MAX_W-1:0] acc, input int dw);
    logic signed [MAX_W-1:0] hi, lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    return acc > hi ? hi : acc < lo ? lo : acc;
  endfunction
endpackage

// File: rtl/fixed_mac.sv
// fixed_mac: combinational signed fixed-point multiply, floor-shift and accumulate
module fixed_mac #(
  parameter int DATA_WIDTH = mlp_pkg::DATA_WIDTH,
  parameter int FRAC_BITS = mlp_pkg::FRAC_BITS,
  parameter int ACC_W = 2 * DATA_WIDTH + 2
) (
  input  logic signed [ACC_W-1:0]      acc_in,
  input  logic signed [DATA_WIDTH-1:0] data,
  input  logic signed [DATA_WIDTH-1:0] weight,
  output logic signed [ACC_W-1:0]      acc_out
);
  logic signed [2*DATA_WIDTH-1:0] prod;
  assign prod = data * weight;
  assign acc_out = acc_in + ACC_W'(prod >>> FRAC_BITS);
endmodule

// File: rtl/output_neuron_seq.sv
// output_neuron_seq: serial weighted sum of hidden activations onto bias, saturated
// score and class bit presented on a valid/ready result port
module output_neuron_seq
  import mlp_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int DATA_WIDTH = mlp_pkg::DATA_WIDTH,
  parameter int FRAC_BITS = mlp_pkg::FRAC_BITS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] weights [NUM_INPUTS],
  input  logic signed [DATA_WIDTH-1:0] bias,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH-1:0] out_score,
  output logic                         out_class,
  output logic                         out_valid,
  input  logic                         out_ready
);
  localparam int ACC_W = 2 * DATA_WIDTH + $clog2(NUM_INPUTS) + 1;
  localparam int IDX_W = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1;
  state_t state, state_next;
  logic [IDX_W-1:0] idx;
  logic signed [ACC_W-1:0] acc, acc_in, acc_next;
  logic signed [DATA_WIDTH-1:0] score_next;
  logic live, accept, last;
  assign in_ready = live && state == ACCUM;
  assign out_valid = state == RESULT;
  assign accept = in_valid && in_ready;
  assign last = idx == IDX_W'(NUM_INPUTS - 1);
  // beat 0 starts from the bias, so a stale acc never leaks into a new inference
  assign acc_in = idx == '0 ? ACC_W'(bias) : acc;
  fixed_mac #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS), .ACC_W(ACC_W)) u_mac (
    .acc_in(acc_in),
    .data(in_data),
    .weight(weights[idx]),
    .acc_out(acc_next)
  );
  assign score_next = DATA_WIDTH'(saturate(MAX_W'(acc_next), DATA_WIDTH));
  always_comb begin
    state_next = state;
    state_next = (accept && last) ? RESULT : (out_valid && out_ready) ? ACCUM : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      live <= 1'b0;
      idx <= '0;
      acc <= '0;
      out_score <= '0;
      out_class <= 1'b0;
    end else begin
      state <= state_next;
      live <= 1'b1;
      if (accept) begin
        acc <= acc_next;
        idx <= last ? '0 : idx + 1'b1;
        if (last) begin
          out_score <= score_next;
          out_class <= score_next > 0;
        end
      end
    end
  end
endmodule

// File: tb/tb_output_neuron_seq.sv
// tb_output_neuron_seq: directed scenarios with hand-computed expected scores
module tb_output_neuron_seq;
  logic clk = 0, rst_n = 0;
  logic signed [15:0] weights [2];
  logic signed [15:0] bias = 0, in_data = 0, out_score;
  logic in_valid = 0, in_ready, out_class, out_valid, out_ready = 0;
  int tests = 0, fails = 0;
  output_neuron_seq #(.NUM_INPUTS(2), .DATA_WIDTH(16), .FRAC_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .weights(weights), .bias(bias), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_score(out_score),
    .out_class(out_class), .out_valid(out_valid), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic send(input logic [15:0] d);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_data = d;
      in_valid = 1;
      if (in_ready) begin
        @(posedge clk);
        #1 in_valid = 0;
        return;
      end
    end
    in_valid = 0;
    tests++; fails++;
    $display("FAIL send_timeout got in_ready=%b want 1", in_ready);
  endtask
  task automatic get_result(output logic [15:0] s, output logic c);
    s = 'x; c = 'x;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        s = out_score; c = out_class; out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        return;
      end
    end
    tests++; fails++;
    $display("FAIL result_timeout got out_valid=%b want 1", out_valid);
  endtask
  task automatic setup(input logic [15:0] w0, w1, b);
    weights[0] = w0; weights[1] = w1; bias = b;
  endtask
  task automatic run(input string name, input logic [15:0] d0, d1, exp_s, input logic exp_c);
    logic [15:0] s;
    logic c;
    send(d0); send(d1);
    tests++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL %s_latency got out_valid=%b want 1", name, out_valid); end
    get_result(s, c);
    tests++;
    if (s !== exp_s) begin fails++; $display("FAIL %s_score got %h want %h", name, s, exp_s); end
    tests++;
    if (c !== exp_c) begin fails++; $display("FAIL %s_class got %b want %b", name, c, exp_c); end
  endtask
  task automatic test_reset;
    #2;
    tests++;
    if ({out_valid, out_score, out_class, in_ready} !== 19'd0) begin fails++; $display("FAIL reset_outputs got v=%b s=%h c=%b r=%b want 0", out_valid, out_score, out_class, in_ready); end
    @(negedge clk); rst_n = 1;
    #1 tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_early got %b want 0", in_ready); end
    @(posedge clk); #1 tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", in_ready); end
  endtask
  task automatic test_basic;
    setup(16'h0100, 16'hFE00, 16'hFF80);
    run("neg", 16'h0100, 16'h0080, 16'hFF80, 1'b0);
    run("pos", 16'h0200, 16'h0000, 16'h0180, 1'b1);
  endtask
  task automatic test_saturation;
    setup(16'h7FFF, 16'h7FFF, 16'h0000);
    run("sat_hi", 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1);
    setup(16'h8000, 16'h8000, 16'h0000);
    run("sat_lo", 16'h7FFF, 16'h7FFF, 16'h8000, 1'b0);
  endtask
  task automatic test_zero;
    setup(16'h0100, 16'h0100, 16'hFF00);
    run("zero", 16'h0080, 16'h0080, 16'h0000, 1'b0);
  endtask
  task automatic test_backpressure;
    logic [15:0] s;
    logic c;
    setup(16'h0100, 16'hFE00, 16'hFF80);
    send(16'h0200);
    repeat (3) @(negedge clk);
    send(16'h0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = i[0] ? 1'b0 : 1'b1;
      in_data = 16'h7FFF;
      tests++;
      if (out_valid !== 1'b1 || out_score !== 16'h0180 || out_class !== 1'b1 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold got v=%b s=%h c=%b r=%b want v=1 s=0180 c=1 r=0", out_valid, out_score, out_class, in_ready);
      end
    end
    in_valid = 0;
    get_result(s, c);
    tests++;
    if (s !== 16'h0180) begin fails++; $display("FAIL stall_score got %h want 0180", s); end
    @(negedge clk) tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL handshake_return got r=%b v=%b want r=1 v=0", in_ready, out_valid); end
    run("b2b_a", 16'h0100, 16'h0080, 16'hFF80, 1'b0);
    run("b2b_b", 16'h0200, 16'h0000, 16'h0180, 1'b1);
  endtask
  task automatic test_reset_mid;
    setup(16'h0100, 16'hFE00, 16'hFF80);
    send(16'h0200);
    #2 rst_n = 0;
    #1 tests++;
    if (out_score !== 16'h0000 || out_class !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid got s=%h c=%b v=%b want 0", out_score, out_class, out_valid);
    end
    @(negedge clk); rst_n = 1;
    run("after_reset", 16'h0200, 16'h0000, 16'h0180, 1'b1);
  endtask
  initial begin
    weights[0] = 0; weights[1] = 0;
    test_reset;
    test_basic;
    test_saturation;
    test_zero;
    test_backpressure;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
